// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-ported unified memory between the fetch (IF) and data (DM) stages.
// Fixed-latency access sequencing with starvation guard, misalignment errors and fetch flush.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned MEM_LAT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              if_err,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic              dm_byte,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              dm_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_byte,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              if_stall,
    output logic              dm_stall,
    output logic              busy
);
    localparam int unsigned LAT_W = 3;
    localparam int unsigned STV_W = 4;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(MEM_LAT);
    localparam logic [STV_W-1:0] STV_TOP  = STV_W'(STARVE_MAX);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ERR} state_t;

    state_t            state, state_nx;
    logic              owner_dm, owner_dm_nx;
    logic              flushed, flushed_nx;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_nx;
    logic [STV_W-1:0]  starve, starve_nx;
    logic [DATA_W-1:0] if_rdata_nx, dm_rdata_nx, mem_wdata_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic              mem_en_nx, mem_we_nx, mem_byte_nx;
    logic              if_ack_nx, if_err_nx, dm_ack_nx, dm_err_nx;
    logic              if_live, flush_now;

    assign if_stall = if_req & ~if_ack;
    assign dm_stall = dm_req & ~dm_ack & ~dm_err;

    // State, bookkeeping and registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner_dm  <= 1'b0;
            flushed   <= 1'b0;
            lat_cnt   <= '0;
            starve    <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            dm_ack    <= 1'b0;
            dm_err    <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_nx;
            owner_dm  <= owner_dm_nx;
            flushed   <= flushed_nx;
            lat_cnt   <= lat_cnt_nx;
            starve    <= starve_nx;
            if_rdata  <= if_rdata_nx;
            dm_rdata  <= dm_rdata_nx;
            if_ack    <= if_ack_nx;
            if_err    <= if_err_nx;
            dm_ack    <= dm_ack_nx;
            dm_err    <= dm_err_nx;
            mem_en    <= mem_en_nx;
            mem_we    <= mem_we_nx;
            mem_byte  <= mem_byte_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            busy      <= (state_nx != IDLE);
        end
    end

    // Next-state and next-output logic; outputs land one cycle after the decision
    always_comb begin
        state_nx     = state;
        owner_dm_nx  = owner_dm;
        flushed_nx   = flushed;
        lat_cnt_nx   = lat_cnt;
        starve_nx    = starve;
        if_rdata_nx  = if_rdata;
        dm_rdata_nx  = dm_rdata;
        mem_we_nx    = mem_we;
        mem_byte_nx  = mem_byte;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        mem_en_nx    = 1'b0;
        if_ack_nx    = 1'b0;
        if_err_nx    = 1'b0;
        dm_ack_nx    = 1'b0;
        dm_err_nx    = 1'b0;
        if_live      = if_req & ~if_flush;
        flush_now    = flushed | (if_flush & ~owner_dm);

        case (state)
            IDLE: begin
                if (dm_req && !(if_live && starve == STV_TOP)) begin
                    owner_dm_nx = 1'b1;
                    flushed_nx  = 1'b0;
                    if (!if_live) begin
                        starve_nx = '0;
                    end else if (starve != STV_TOP) begin
                        starve_nx = starve + 1'b1;
                    end
                    if (!dm_byte && dm_addr[0]) begin
                        state_nx  = ERR;
                        dm_err_nx = 1'b1;
                    end else begin
                        state_nx     = ISSUE;
                        mem_en_nx    = 1'b1;
                        mem_we_nx    = dm_we;
                        mem_byte_nx  = dm_byte;
                        mem_addr_nx  = dm_addr;
                        mem_wdata_nx = dm_wdata;
                    end
                end else if (if_live) begin
                    owner_dm_nx = 1'b0;
                    flushed_nx  = 1'b0;
                    starve_nx   = '0;
                    if (if_addr[0]) begin
                        state_nx  = ERR;
                        if_err_nx = 1'b1;
                    end else begin
                        state_nx    = ISSUE;
                        mem_en_nx   = 1'b1;
                        mem_we_nx   = 1'b0;
                        mem_byte_nx = 1'b0;
                        mem_addr_nx = if_addr;
                    end
                end
            end
            ISSUE: begin
                lat_cnt_nx = LAT_LOAD;
                flushed_nx = flush_now;
                state_nx   = WAIT;
            end
            WAIT: begin
                flushed_nx = flush_now;
                lat_cnt_nx = lat_cnt - 1'b1;
                if (lat_cnt == LAT_W'(1)) begin
                    state_nx = RESP;
                    if (owner_dm) begin
                        dm_ack_nx = 1'b1;
                        if (!mem_we) dm_rdata_nx = mem_rdata;
                    end else if (!flush_now) begin
                        // A flushed fetch still runs its memory timing but is never acknowledged
                        if_ack_nx   = 1'b1;
                        if_rdata_nx = mem_rdata;
                    end
                end
            end
            RESP:    state_nx = IDLE;
            ERR:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of arbitration, latency and read data.
module tb_mem_port_arbiter;
    localparam int unsigned ADDR_W     = 16;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned MEM_LAT    = 2;
    localparam int unsigned STARVE_MAX = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              if_req, if_flush, if_ack, if_err;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req, dm_we, dm_byte, dm_ack, dm_err;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata, dm_rdata;
    logic              mem_en, mem_we, mem_byte;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              if_stall, dm_stall, busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
        .dm_req(dm_req), .dm_we(dm_we), .dm_byte(dm_byte), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .if_stall(if_stall), .dm_stall(dm_stall), .busy(busy)
    );

    // Memory: data is valid exactly MEM_LAT cycles after the mem_en cycle, noise otherwise
    logic [3:0]  mcnt = '0;
    logic [15:0] maddr = '0;
    logic [15:0] noise = '0;
    logic [16:0] force_val = '0;

    function automatic logic [15:0] memf(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    always @(posedge clock) begin
        noise <= 16'($urandom);
        if (mem_en) begin
            mcnt  <= 4'(MEM_LAT);
            maddr <= mem_addr;
        end else if (mcnt != 4'd0) begin
            mcnt <= mcnt - 4'd1;
        end
    end
    assign mem_rdata = (mcnt == 4'd1) ? (force_val[16] ? force_val[15:0] : memf(maddr)) : noise;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({if_ack, if_err, dm_ack, dm_err, mem_en, mem_we, mem_byte, busy} !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000000",
                     {if_ack, if_err, dm_ack, dm_err, mem_en, mem_we, mem_byte, busy});
        end
        checks++;
        if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_data: got %h want 0", {mem_addr, mem_wdata, if_rdata, dm_rdata});
        end
        repeat (2) tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_if_read();
        force_val = {1'b1, 16'h1234};
        if_req = 1'b1;
        if_addr = 16'h0010;
        #1;
        checks++;
        if (if_stall !== 1'b1) begin errors++; $display("FAIL if_read_stall c0: got %b want 1", if_stall); end
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if (mem_en !== (c == 1)) begin errors++; $display("FAIL if_read_mem_en c%0d: got %b want %b", c, mem_en, c == 1); end
            checks++;
            if (if_ack !== (c == 4)) begin errors++; $display("FAIL if_read_ack c%0d: got %b want %b", c, if_ack, c == 4); end
            checks++;
            if (if_stall !== (c != 4)) begin errors++; $display("FAIL if_read_stall c%0d: got %b want %b", c, if_stall, c != 4); end
        end
        checks++;
        if (if_rdata !== 16'h1234) begin errors++; $display("FAIL if_read_rdata: got %h want 1234", if_rdata); end
        tick();
        if_req = 1'b0;
        force_val = '0;
        tick();
    endtask

    task automatic test_dm_write();
        dm_req = 1'b1; dm_we = 1'b1; dm_byte = 1'b0; dm_addr = 16'h0040; dm_wdata = 16'hBEEF;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if ({mem_en, mem_we, mem_byte} !== 3'b110 || mem_addr !== 16'h0040 || mem_wdata !== 16'hBEEF) begin
                    errors++;
                    $display("FAIL dm_write_issue: got en/we/byte %b addr %h wdata %h want 110 0040 beef",
                             {mem_en, mem_we, mem_byte}, mem_addr, mem_wdata);
                end
            end
            checks++;
            if (dm_ack !== (c == 4)) begin errors++; $display("FAIL dm_write_ack c%0d: got %b want %b", c, dm_ack, c == 4); end
        end
        checks++;
        if (dm_rdata !== 16'h0000) begin errors++; $display("FAIL dm_write_rdata: got %h want 0000", dm_rdata); end
        tick();
        dm_req = 1'b0; dm_we = 1'b0;
        tick();
    endtask

    task automatic test_starve();
        string got;
        int n, last;
        got = ""; n = 0; last = -1;
        if_req = 1'b1; if_addr = 16'h0100;
        dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 16'h0200;
        for (int c = 0; c < 200 && n < 10; c++) begin
            tick();
            if (dm_ack || if_ack) begin
                got = {got, dm_ack ? "D" : "I"};
                n++;
                if (last >= 0) begin
                    checks++;
                    if (c - last != int'(MEM_LAT) + 3) begin
                        errors++; $display("FAIL starve_gap: got %0d want %0d", c - last, MEM_LAT + 3);
                    end
                end
                last = c;
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
        checks++;
        if (got != "DDDDIDDDDI") begin errors++; $display("FAIL starve_order: got %s want DDDDIDDDDI", got); end
        checks++;
        if (if_rdata !== memf(16'h0100) || dm_rdata !== memf(16'h0200)) begin
            errors++; $display("FAIL starve_rdata: got %h %h want %h %h", if_rdata, dm_rdata, memf(16'h0100), memf(16'h0200));
        end
        repeat (2) tick();
    endtask

    task automatic test_misaligned();
        dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 16'h0041;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 2) dm_req = 1'b0;
            checks++;
            if ({dm_err, dm_ack, mem_en} !== {c == 1, 2'b00}) begin
                errors++; $display("FAIL misalign_dm c%0d: got err/ack/en %b want %b", c, {dm_err, dm_ack, mem_en}, {c == 1, 2'b00});
            end
            if (c == 1) begin
                checks++;
                if (dm_stall !== 1'b0) begin errors++; $display("FAIL misalign_stall: got %b want 0", dm_stall); end
            end
        end
        dm_req = 1'b1; dm_byte = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            if (c == 1) begin
                checks++;
                if ({mem_en, mem_byte} !== 2'b11 || mem_addr !== 16'h0041) begin
                    errors++; $display("FAIL byte_issue: got en/byte %b addr %h want 11 0041", {mem_en, mem_byte}, mem_addr);
                end
            end
            checks++;
            if ({dm_ack, dm_err} !== {c == 4, 1'b0}) begin
                errors++; $display("FAIL byte_ack c%0d: got ack/err %b want %b", c, {dm_ack, dm_err}, {c == 4, 1'b0});
            end
        end
        checks++;
        if (dm_rdata !== memf(16'h0041)) begin errors++; $display("FAIL byte_rdata: got %h want %h", dm_rdata, memf(16'h0041)); end
        tick();
        dm_req = 1'b0; dm_byte = 1'b0;
        if_req = 1'b1; if_addr = 16'h0011;
        tick();
        checks++;
        if ({if_err, mem_en} !== 2'b10) begin errors++; $display("FAIL misalign_if: got err/en %b want 10", {if_err, mem_en}); end
        if_req = 1'b0;
        tick();
        checks++;
        if (if_rdata !== memf(16'h0100)) begin errors++; $display("FAIL misalign_if_rdata: got %h want %h", if_rdata, memf(16'h0100)); end
    endtask

    task automatic test_flush();
        int en_cnt;
        en_cnt = 0;
        tick();
        if_req = 1'b1; if_addr = 16'h0020;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 2) begin
                if_flush = 1'b1; if_req = 1'b0;
                dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 16'h0080;
            end else begin
                if_flush = 1'b0;
            end
            if (c <= 5 && mem_en) en_cnt++;
            checks++;
            if (if_ack !== 1'b0) begin errors++; $display("FAIL flush_if_ack c%0d: got %b want 0", c, if_ack); end
            if (c >= 6) begin
                checks++;
                if (mem_en !== (c == 6) || dm_ack !== (c == 9)) begin
                    errors++; $display("FAIL flush_dm c%0d: got en/ack %b want %b", c, {mem_en, dm_ack}, {c == 6, c == 9});
                end
            end
            if (c == 9) dm_req = 1'b0;
        end
        checks++;
        if (en_cnt != 1) begin errors++; $display("FAIL flush_mem_en_count: got %0d want 1", en_cnt); end
        checks++;
        if (if_rdata !== memf(16'h0100) || dm_rdata !== memf(16'h0080)) begin
            errors++; $display("FAIL flush_rdata: got %h %h want %h %h", if_rdata, dm_rdata, memf(16'h0100), memf(16'h0080));
        end
        // Flush in IDLE masks the request; flush on the ack cycle does not cancel the ack
        tick();
        if_req = 1'b1; if_flush = 1'b1; if_addr = 16'h0030;
        tick();
        if_flush = 1'b0;
        checks++;
        if ({mem_en, busy} !== 2'b00) begin errors++; $display("FAIL flush_idle: got en/busy %b want 00", {mem_en, busy}); end
        for (int c = 2; c <= 5; c++) begin
            tick();
            if (c == 5) if_flush = 1'b1;
            checks++;
            if ({mem_en, if_ack} !== {c == 2, c == 5}) begin
                errors++; $display("FAIL flush_ack c%0d: got en/ack %b want %b", c, {mem_en, if_ack}, {c == 2, c == 5});
            end
        end
        checks++;
        if (if_rdata !== memf(16'h0030)) begin errors++; $display("FAIL flush_ack_rdata: got %h want %h", if_rdata, memf(16'h0030)); end
        tick();
        if_flush = 1'b0; if_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        dm_req = 1'b1; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = 16'h0060;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, mem_en, dm_ack} !== 3'b000 || mem_addr !== 16'h0 || dm_rdata !== 16'h0 || if_rdata !== 16'h0) begin
            errors++; $display("FAIL reset_mid: got busy/en/ack %b addr %h rdata %h %h want 0",
                               {busy, mem_en, dm_ack}, mem_addr, dm_rdata, if_rdata);
        end
        dm_req = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++;
            if ({dm_ack, mem_en} !== 2'b00) begin errors++; $display("FAIL reset_stale c%0d: got ack/en %b want 00", c, {dm_ack, mem_en}); end
        end
        dm_req = 1'b1; dm_addr = 16'h0062;
        for (int c = 1; c <= 4; c++) begin
            tick();
            checks++;
            if ({mem_en, dm_ack} !== {c == 1, c == 4}) begin
                errors++; $display("FAIL reset_new c%0d: got en/ack %b want %b", c, {mem_en, dm_ack}, {c == 1, c == 4});
            end
        end
        checks++;
        if (dm_rdata !== memf(16'h0062)) begin errors++; $display("FAIL reset_new_rdata: got %h want %h", dm_rdata, memf(16'h0062)); end
        tick();
        dm_req = 1'b0;
        tick();
    endtask

    // Transaction-level model: a grant at cycle g completes at g+1 (err) or g+MEM_LAT+2 (ack)
    task automatic test_random();
        bit ia, ig, da, dg, ierr, derr;
        int idone, ddone, free_at, issue_at, starve;
        logic [15:0] ia_addr, da_addr, da_wdata, exp_if, exp_dm, i_pend, d_pend, m_addr;
        bit da_we, da_byte, m_we, m_byte;
        ia = 0; ig = 0; da = 0; dg = 0; ierr = 0; derr = 0;
        idone = -1; ddone = -1; free_at = 0; issue_at = -1; starve = 0;
        ia_addr = '0; da_addr = '0; da_wdata = '0; da_we = 0; da_byte = 0;
        exp_if = '0; exp_dm = '0; i_pend = '0; d_pend = '0; m_addr = '0; m_we = 0; m_byte = 0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (ig && c == idone && !ierr) exp_if = i_pend;
            if (dg && c == ddone && !derr) exp_dm = d_pend;
            checks++;
            if ({if_ack, if_err} !== {ig && c == idone && !ierr, ig && c == idone && ierr}) begin
                errors++; $display("FAIL rnd_if_resp c%0d: got ack/err %b want %b", c, {if_ack, if_err},
                                   {ig && c == idone && !ierr, ig && c == idone && ierr});
            end
            checks++;
            if ({dm_ack, dm_err} !== {dg && c == ddone && !derr, dg && c == ddone && derr}) begin
                errors++; $display("FAIL rnd_dm_resp c%0d: got ack/err %b want %b", c, {dm_ack, dm_err},
                                   {dg && c == ddone && !derr, dg && c == ddone && derr});
            end
            checks++;
            if (mem_en !== (c == issue_at)) begin errors++; $display("FAIL rnd_mem_en c%0d: got %b want %b", c, mem_en, c == issue_at); end
            if (c == issue_at) begin
                checks++;
                if (mem_addr !== m_addr || {mem_we, mem_byte} !== {m_we, m_byte}) begin
                    errors++; $display("FAIL rnd_mem_cmd c%0d: got %h %b want %h %b", c, mem_addr, {mem_we, mem_byte}, m_addr, {m_we, m_byte});
                end
            end
            checks++;
            if (if_rdata !== exp_if || dm_rdata !== exp_dm) begin
                errors++; $display("FAIL rnd_rdata c%0d: got %h %h want %h %h", c, if_rdata, dm_rdata, exp_if, exp_dm);
            end
            // Requesters release the cycle after completion and may start anew at once
            if (ig && c > idone) begin ia = 0; ig = 0; end
            if (dg && c > ddone) begin da = 0; dg = 0; end
            if (!ia && $urandom_range(0, 2) != 0) begin
                ia = 1;
                ia_addr = 16'($urandom);
                ia_addr[0] = ($urandom_range(0, 5) == 0);
            end
            if (!da && $urandom_range(0, 2) != 0) begin
                da = 1;
                da_addr = 16'($urandom);
                da_addr[0] = ($urandom_range(0, 3) == 0);
                da_we = 1'($urandom_range(0, 1));
                da_byte = ($urandom_range(0, 3) == 0);
                da_wdata = 16'($urandom);
            end
            if_req = ia; if_addr = ia ? ia_addr : 16'($urandom);
            dm_req = da; dm_addr = da_addr; dm_we = da_we; dm_byte = da_byte; dm_wdata = da_wdata;
            #1;
            checks++;
            if ({if_stall, dm_stall} !== {ia && !(ig && c == idone && !ierr), da && !(dg && c == ddone)}) begin
                errors++; $display("FAIL rnd_stall c%0d: got %b want %b", c, {if_stall, dm_stall},
                                   {ia && !(ig && c == idone && !ierr), da && !(dg && c == ddone)});
            end
            if (c >= free_at && ((da && !dg) || (ia && !ig))) begin
                if (da && !dg && !(ia && !ig && starve == int'(STARVE_MAX))) begin
                    starve = (ia && !ig) ? ((starve < int'(STARVE_MAX)) ? starve + 1 : starve) : 0;
                    dg = 1;
                    derr = !da_byte && da_addr[0];
                    ddone = derr ? c + 1 : c + int'(MEM_LAT) + 2;
                    d_pend = da_we ? exp_dm : memf(da_addr);
                    if (!derr) begin issue_at = c + 1; m_addr = da_addr; m_we = da_we; m_byte = da_byte; end
                    free_at = ddone + 1;
                end else begin
                    starve = 0;
                    ig = 1;
                    ierr = ia_addr[0];
                    idone = ierr ? c + 1 : c + int'(MEM_LAT) + 2;
                    i_pend = memf(ia_addr);
                    if (!ierr) begin issue_at = c + 1; m_addr = ia_addr; m_we = 0; m_byte = 0; end
                    free_at = idone + 1;
                end
            end
        end
        if_req = 1'b0; dm_req = 1'b0;
    endtask

    initial begin
        if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_byte = 1'b0; dm_addr = '0; dm_wdata = '0;
        test_reset();
        test_if_read();
        test_dm_write();
        test_starve();
        test_misaligned();
        test_flush();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
